// File: rtl/button_debounce.sv
// button_debounce: conditions N raw bouncy pushbuttons into clean clk-domain level, press, release and auto-repeat signals
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset (0 = reset)
//   btn_raw      raw button pins, asynchronous to clk, active-high
//   btn_level    debounced level
//   btn_press    1-cycle pulse on debounced 0->1
//   btn_release  1-cycle pulse on debounced 1->0
//   btn_repeat   1-cycle auto-repeat pulse while held
module button_debounce #(
   parameter int N_BTN         = 5,
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);
   localparam int MAX_DR = DEBOUNCE_CYC > REPEAT_DELAY ? DEBOUNCE_CYC : REPEAT_DELAY;
   localparam int MAX_ALL = MAX_DR > REPEAT_PERIOD ? MAX_DR : REPEAT_PERIOD;
   localparam int CW = $clog2(MAX_ALL + 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] R_DELAY = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] R_PERIOD = CW'(REPEAT_PERIOD);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
   logic [N_BTN-1:0] s1_q, s2_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_raw;
         s2_q <= s1_q;
      end
   for (genvar c = 0; c < N_BTN; c++) begin : g_ch
      state_t state_q, state_d;
      logic [CW-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d, rcnt_inc;
      logic rep_q, rep_d, rep_hit;
      logic level_q, level_d, press_q, press_d, release_q, release_d, repeat_q, repeat_d;
      always_comb begin
         state_d   = state_q;
         dcnt_d    = dcnt_q;
         rcnt_d    = rcnt_q;
         rep_d     = rep_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         repeat_d  = 1'b0;
         rcnt_inc  = rcnt_q + ONE;
         // rep_q marks that the first repeat has fired; afterwards rcnt measures the period
         rep_hit   = (REPEAT_DELAY > 0) && (rcnt_inc == (rep_q ? R_PERIOD : R_DELAY));
         unique case (state_q)
            IDLE:
               if (s2_q[c]) begin
                  state_d = PRESS_WAIT;
                  dcnt_d  = ONE;
               end
            PRESS_WAIT:
               if (!s2_q[c]) begin
                  state_d = IDLE;
                  dcnt_d  = '0;
               end else if (dcnt_q >= D_LAST) begin
                  state_d = HELD;
                  dcnt_d  = '0;
                  rcnt_d  = '0;
                  rep_d   = 1'b0;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else
                  dcnt_d = dcnt_q + ONE;
            HELD:
               if (!s2_q[c]) begin
                  state_d = RELEASE_WAIT;
                  dcnt_d  = ONE;
               end else if (REPEAT_DELAY > 0) begin
                  // clearing on each hit keeps rcnt bounded without a modulo
                  rcnt_d   = rep_hit ? '0 : rcnt_inc;
                  rep_d    = rep_q | rep_hit;
                  repeat_d = rep_hit;
               end
            RELEASE_WAIT:
               // a bounce back to high resumes HELD with rcnt untouched
               if (s2_q[c]) begin
                  state_d = HELD;
                  dcnt_d  = '0;
               end else if (dcnt_q >= D_LAST) begin
                  state_d   = IDLE;
                  dcnt_d    = '0;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else
                  dcnt_d = dcnt_q + ONE;
         endcase
      end
      always_ff @(posedge clk or negedge reset)
         if (!reset) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            rep_q     <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
         end
      assign btn_level[c]   = level_q;
      assign btn_press[c]   = press_q;
      assign btn_release[c] = release_q;
      assign btn_repeat[c]  = repeat_q;
   end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: table-driven check of button_debounce with repeat enabled and disabled
module tb_button_debounce;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [1:0] btn_raw = 2'b00;
   logic [1:0] lvl, prs, rel, rpt, lvl0, prs0, rel0, rpt0;
   int n_tests = 0;
   int n_fail = 0;
   typedef struct {
      logic       r;
      logic [1:0] raw, l, p, rl, rp;
   } vec_t;
   vec_t vq[$];
   always #5 clk = ~clk;
   button_debounce #(.N_BTN(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rpt));
   button_debounce #(.N_BTN(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)) dut_norep (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_repeat(rpt0));
   task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask
   task automatic add(input logic r, input logic [1:0] raw, input logic [1:0] l, input logic [1:0] p,
                      input logic [1:0] rl, input logic [1:0] rp, input int n);
      vec_t v;
      v.r = r; v.raw = raw; v.l = l; v.p = p; v.rl = rl; v.rp = rp;
      for (int i = 0; i < n; i++) vq.push_back(v);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      // reset with both pins high, then both press 6 edges after release
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1);
      add(1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add(1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // clean press on ch0
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
      add(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);
      add(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      // bounce: high 3, low 1, high 2, low -> nothing; then high 4 -> one press
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(1, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1);
      add(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      // long hold: repeats at HELD cycles 10,13,16,19,22 then release
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
      for (int k = 1; k <= 22; k++)
         add(1, 2'b01, 2'b01, 2'b00, 2'b00, (k == 10 || k == 13 || k == 16 || k == 19 || k == 22) ? 2'b01 : 2'b00, 1);
      add(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // release bounce while held: rcnt frozen 3 edges, repeats shift to 13,16
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
      add(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2);
      for (int k = 6; k <= 16; k++)
         add(1, 2'b01, 2'b01, 2'b00, 2'b00, (k == 13 || k == 16) ? 2'b01 : 2'b00, 1);
      add(1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // reset with ch0 HELD and ch1 in PRESS_WAIT: no release pulse afterwards
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4);
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 1);
      add(1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 7);
      foreach (vq[i]) begin
         reset = vq[i].r;
         btn_raw = vq[i].raw;
         tick;
         chk("level", i, lvl, vq[i].l);
         chk("press", i, prs, vq[i].p);
         chk("release", i, rel, vq[i].rl);
         chk("repeat", i, rpt, vq[i].rp);
         chk("norep_level", i, lvl0, vq[i].l);
         chk("norep_press", i, prs0, vq[i].p);
         chk("norep_release", i, rel0, vq[i].rl);
         chk("norep_repeat", i, rpt0, 2'b00);
      end
      // asynchronous reset assertion between clock edges
      btn_raw = 2'b01;
      repeat (5) tick;
      chk("async_pre_level", 0, lvl, 2'b00);
      tick;
      chk("async_press", 0, prs, 2'b01);
      chk("async_held_level", 0, lvl, 2'b01);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_level", 0, lvl, 2'b00);
      chk("async_press_clr", 0, prs, 2'b00);
      btn_raw = 2'b00;
      tick;
      chk("async_release", 0, rel, 2'b00);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("post_reset_release", i, rel, 2'b00);
         chk("post_reset_level", i, lvl, 2'b00);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
